// File: rtl/mult_cell_pipe.sv
// mult_cell_pipe -- pipelined DATA_W x DATA_W multiplier cell with tag sideband.
//
// Stage 1 registers four (DATA_W/2)x(DATA_W/2) unsigned partial products plus a
// sign-correction term; stage 2 sums them into the full 2*DATA_W product and
// selects the requested half. A single advance enable (adv) moves every stage,
// so back-pressure on out_ready stalls the whole pipe without losing data.
//
// Optional build macro: MULT_CELL_PIPE_OUT_REG_EN adds a third output register
// stage (latency 3 instead of 2).
//
// Ports:
//   clk        sole clock, rising edge
//   reset_n    synchronous active-low reset
//   in_valid   operation offered         in_ready  operation accepted (= adv)
//   src1/src2  operands A/B              op        00 MUL, 01 MULXUU, 10 MULXSU, 11 MULXSS
//   in_tag     sideband tag in           out_tag   tag of the operation in result
//   out_valid  result available          out_ready consumer takes result
//   result     selected product half     ovf       MUL signed overflow flag
module mult_cell_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [1:0]        op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              ovf,
    output logic [TAG_W-1:0]  out_tag
);
    localparam int HALF_W = DATA_W / 2;
    localparam int PROD_W = 2 * DATA_W;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSU = 2'b10;
    localparam logic [1:0] OP_MULXSS = 2'b11;

    // Unsigned partial products recombined, then the signed correction is
    // removed: A_s*B_s = A_u*B_u - (a_neg*B_u + b_neg*A_u)*2^W  (mod 2^2W).
    function automatic logic signed [PROD_W-1:0] combine_product(
        input logic [DATA_W-1:0] pp_ll,
        input logic [DATA_W-1:0] pp_lh,
        input logic [DATA_W-1:0] pp_hl,
        input logic [DATA_W-1:0] pp_hh,
        input logic [DATA_W:0]   corr
    );
        logic [PROD_W-1:0] mid;
        logic [PROD_W-1:0] acc;
        mid = {{(PROD_W-DATA_W-1){1'b0}}, ({1'b0, pp_lh} + {1'b0, pp_hl})};
        acc = {pp_hh, pp_ll} + (mid << HALF_W)
              - ({{(DATA_W-1){1'b0}}, corr} << DATA_W);
        return $signed(acc);
    endfunction

    // Signed overflow of the low half: upper half is not a pure sign extension.
    function automatic logic mul_overflow(input logic signed [PROD_W-1:0] prod);
        return prod[PROD_W-1:DATA_W] != {DATA_W{prod[DATA_W-1]}};
    endfunction

    logic adv;

    logic              a_signed;
    logic              b_signed;
    logic [DATA_W-1:0] a_lo, a_hi, b_lo, b_hi;
    logic [DATA_W-1:0] pp_ll_p1_d, pp_lh_p1_d, pp_hl_p1_d, pp_hh_p1_d;
    logic [DATA_W:0]   corr_p1_d;

    logic              vld_p1_q;
    logic [DATA_W-1:0] pp_ll_p1_q, pp_lh_p1_q, pp_hl_p1_q, pp_hh_p1_q;
    logic [DATA_W:0]   corr_p1_q;
    logic [1:0]        op_p1_q;
    logic [TAG_W-1:0]  tag_p1_q;

    logic signed [PROD_W-1:0] prod_p2;
    logic [DATA_W-1:0]        res_p2_d;
    logic                     ovf_p2_d;

    logic              vld_p2_q;
    logic [DATA_W-1:0] res_p2_q;
    logic              ovf_p2_q;
    logic [TAG_W-1:0]  tag_p2_q;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---- stage 0 -> 1: split operands, form partial products and correction
    always_comb begin
        b_signed   = (op == OP_MUL) || (op == OP_MULXSS);
        a_signed   = b_signed || (op == OP_MULXSU);
        a_lo       = {{HALF_W{1'b0}}, src1[HALF_W-1:0]};
        a_hi       = {{HALF_W{1'b0}}, src1[DATA_W-1:HALF_W]};
        b_lo       = {{HALF_W{1'b0}}, src2[HALF_W-1:0]};
        b_hi       = {{HALF_W{1'b0}}, src2[DATA_W-1:HALF_W]};
        pp_ll_p1_d = a_lo * b_lo;
        pp_lh_p1_d = a_lo * b_hi;
        pp_hl_p1_d = a_hi * b_lo;
        pp_hh_p1_d = a_hi * b_hi;
        corr_p1_d  = '0;
        if (a_signed && src1[DATA_W-1]) begin
            corr_p1_d = corr_p1_d + {1'b0, src2};
        end
        if (b_signed && src2[DATA_W-1]) begin
            corr_p1_d = corr_p1_d + {1'b0, src1};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1_q <= 1'b0;
        end else if (adv) begin
            vld_p1_q <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            pp_ll_p1_q <= pp_ll_p1_d;
            pp_lh_p1_q <= pp_lh_p1_d;
            pp_hl_p1_q <= pp_hl_p1_d;
            pp_hh_p1_q <= pp_hh_p1_d;
            corr_p1_q  <= corr_p1_d;
            op_p1_q    <= op;
            tag_p1_q   <= in_tag;
        end
    end

    // ---- stage 1 -> 2: combine, sign-correct, select half, flag overflow
    always_comb begin
        prod_p2  = combine_product(pp_ll_p1_q, pp_lh_p1_q, pp_hl_p1_q, pp_hh_p1_q, corr_p1_q);
        res_p2_d = (op_p1_q == OP_MUL) ? prod_p2[DATA_W-1:0] : prod_p2[PROD_W-1:DATA_W];
        ovf_p2_d = (op_p1_q == OP_MUL) && mul_overflow(prod_p2);
    end

    // Bubbles leave the data registers untouched so no stale value of a
    // discarded operation surfaces after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p2_q <= 1'b0;
            res_p2_q <= '0;
            ovf_p2_q <= 1'b0;
            tag_p2_q <= '0;
        end else if (adv) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                res_p2_q <= res_p2_d;
                ovf_p2_q <= ovf_p2_d;
                tag_p2_q <= tag_p1_q;
            end
        end
    end

`ifdef MULT_CELL_PIPE_OUT_REG_EN
    logic              vld_p3_q;
    logic [DATA_W-1:0] res_p3_q;
    logic              ovf_p3_q;
    logic [TAG_W-1:0]  tag_p3_q;

    // ---- stage 2 -> 3: optional output register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p3_q <= 1'b0;
            res_p3_q <= '0;
            ovf_p3_q <= 1'b0;
            tag_p3_q <= '0;
        end else if (adv) begin
            vld_p3_q <= vld_p2_q;
            if (vld_p2_q) begin
                res_p3_q <= res_p2_q;
                ovf_p3_q <= ovf_p2_q;
                tag_p3_q <= tag_p2_q;
            end
        end
    end

    assign out_valid = vld_p3_q;
    assign result    = res_p3_q;
    assign ovf       = ovf_p3_q;
    assign out_tag   = tag_p3_q;
`else
    assign out_valid = vld_p2_q;
    assign result    = res_p2_q;
    assign ovf       = ovf_p2_q;
    assign out_tag   = tag_p2_q;
`endif

endmodule

// File: tb/tb_mult_cell_pipe.sv
module tb_mult_cell_pipe;
    localparam int DW = 32;
    localparam int TW = 4;
`ifdef MULT_CELL_PIPE_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] src1 = '0;
    logic [DW-1:0] src2 = '0;
    logic [1:0]    op = 2'b00;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] result;
    logic          ovf;
    logic [TW-1:0] out_tag;

    typedef struct packed {
        logic [DW-1:0] res;
        logic          ovf;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mult_cell_pipe #(.DATA_W(DW), .TAG_W(TW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .op        (op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .out_tag   (out_tag)
    );

    // Reference: sign/zero-extend to 2*DW and multiply directly.
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [1:0] o, input logic [TW-1:0] t);
        logic signed [2*DW-1:0] sa, sb, p;
        exp_t e;
        sa = (o == 2'b01) ? {{DW{1'b0}}, a} : {{DW{a[DW-1]}}, a};
        sb = (o == 2'b00 || o == 2'b11) ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
        p  = sa * sb;
        e.res = (o == 2'b00) ? p[DW-1:0] : p[2*DW-1:DW];
        e.ovf = (o == 2'b00) && (p[2*DW-1:DW] != {DW{p[DW-1]}});
        e.tag = t;
        return e;
    endfunction

    function automatic logic [DW-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: every consumed result is popped and compared in order.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got res=%h ovf=%b tag=%0d, required no output",
                         result, ovf, out_tag);
            end else begin
                e = sb_q.pop_front();
                if ({result, ovf, out_tag} !== e) begin
                    n_bad++;
                    $display("FAIL sb_result: got res=%h ovf=%b tag=%0d, required res=%h ovf=%b tag=%0d",
                             result, ovf, out_tag, e.res, e.ovf, e.tag);
                end
            end
        end
    end

    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [1:0] o, input logic [TW-1:0] t);
        bit acc;
        acc = 1'b0;
        src1 = a; src2 = b; op = o; in_tag = t; in_valid = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(model(a, b, o, t));
                acc = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_bad++;
            $display("FAIL issue_timeout: got accepted=0, required accepted=1");
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, required 0", sb_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b1; src1 = 32'd9; src2 = 32'd9; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp += 5;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        if (result !== '0)      begin n_bad++; $display("FAIL rst_result: got %h, required 0", result); end
        if (ovf !== 1'b0)       begin n_bad++; $display("FAIL rst_ovf: got %b, required 0", ovf); end
        if (out_tag !== '0)     begin n_bad++; $display("FAIL rst_out_tag: got %0d, required 0", out_tag); end
        if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset_n  = 1'b1;
        // in_valid asserted during reset must not have produced an operation
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_ignored_in: got out_valid=%b, required 0", out_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_basic();
        int k;
        k = 0;
        out_ready = 1'b1;
        issue(32'd7, 32'd6, 2'b00, 4'd3);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (out_valid) begin k = i; break; end
        end
        n_cmp += 4;
        if (k != LAT)                 begin n_bad++; $display("FAIL basic_latency: got %0d, required %0d", k, LAT); end
        if (result !== 32'h0000_002A) begin n_bad++; $display("FAIL basic_result: got %h, required 0000002a", result); end
        if (ovf !== 1'b0)             begin n_bad++; $display("FAIL basic_ovf: got %b, required 0", ovf); end
        if (out_tag !== 4'd3)         begin n_bad++; $display("FAIL basic_tag: got %0d, required 3", out_tag); end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 4'd7);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 4'd8);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 4'd9);
        drain();
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        issue(32'h0001_0000, 32'h0001_0000, 2'b00, 4'd4);
        issue(32'hFFFF_FFFF, 32'h0000_0005, 2'b00, 4'd5);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 4'd6);
        issue(32'h8000_0000, 32'h8000_0000, 2'b11, 4'd10);
        drain();
    endtask

    task automatic test_stall();
        exp_t e1;
        bit   t3_acc;
        t3_acc = 1'b0;
        e1 = model(32'd11, 32'd3, 2'b00, 4'd1);
        out_ready = 1'b0;
        op = 2'b00; src2 = 32'd3;
        for (int t = 1; t <= 2; t++) begin
            src1 = 32'd10 + 32'(t); in_tag = TW'(t); in_valid = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_accept%0d: got in_ready=%b, required 1", t, in_ready); end
            sb_q.push_back(model(src1, src2, op, in_tag));
            @(posedge clk); #1;
        end
        src1 = 32'd13; in_tag = 4'd3; in_valid = 1'b1;
        for (int i = 0; i < LAT - 2; i++) begin
            @(negedge clk);
            if (in_ready) begin sb_q.push_back(model(src1, src2, op, in_tag)); t3_acc = 1'b1; end
            @(posedge clk); #1;
            if (t3_acc) in_valid = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp += 4;
            if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %b, required 1", out_valid); end
            if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
            if (result !== e1.res)  begin n_bad++; $display("FAIL stall_hold_result: got %h, required %h", result, e1.res); end
            if (out_tag !== 4'd1)   begin n_bad++; $display("FAIL stall_hold_tag: got %0d, required 1", out_tag); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            if (!t3_acc && in_valid) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b, required 1", in_ready); end
                sb_q.push_back(model(src1, src2, op, in_tag));
                t3_acc = 1'b1;
            end
            n_cmp++;
            if (out_valid !== 1'b1 || out_tag !== TW'(t)) begin
                n_bad++;
                $display("FAIL release_order%0d: got valid=%b tag=%0d, required valid=1 tag=%0d", t, out_valid, out_tag, t);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        drain();
    endtask

    task automatic test_reset_flight();
        out_ready = 1'b0;
        op = 2'b00; src1 = 32'd5; src2 = 32'd5;
        in_tag = 4'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_tag = 4'd6;
        @(posedge clk); #1;
        reset_n = 1'b0; in_tag = 4'd7;
        @(posedge clk); #1;
        reset_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        n_cmp += 5;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b, required 0", out_valid); end
        if (result !== '0)      begin n_bad++; $display("FAIL flush_result: got %h, required 0", result); end
        if (ovf !== 1'b0)       begin n_bad++; $display("FAIL flush_ovf: got %b, required 0", ovf); end
        if (out_tag !== '0)     begin n_bad++; $display("FAIL flush_tag: got %0d, required 0", out_tag); end
        if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL flush_in_ready: got %b, required 1", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL flush_stale: got out_valid=%b tag=%0d, required 0", out_valid, out_tag);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 200; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            src1      = pick();
            src2      = pick();
            op        = 2'($urandom);
            in_tag    = TW'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_valid && in_ready) sb_q.push_back(model(src1, src2, op, in_tag));
            @(posedge clk); #1;
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_stall();
        test_reset_flight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
